pipe_stage_latch: RTL and testbench

//  Parametrised inter-stage latch for the LC-3b pipeline. Replaces per-field load-enable stage banks.

---
 rtl/pipe_stage_latch.sv | 177 +++++++++++++++++
 tb/tb_pipe_stage_latch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_latch.sv
// Purpose : LC-3b inter-stage latch; carries one stage bundle (npc, cs, ir, sr1, sr2, cc, drid)
// Latency : 1 cycle from accept (up_valid&&up_ready) to dn_valid; order preserved, 1 beat/cycle
// Backpr. : 2-entry skid (main + skid); up_ready = !skid valid, so it is a pure register output
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous squash of all held beats; an offered beat that cycle is dropped
//   up_valid/up_ready upstream handshake; *_in bundle fields
//   dn_valid/dn_ready downstream handshake; *_out bundle fields, driven from the main register
//   stall_cnt         cycles with dn_valid && !dn_ready   (only with PIPE_STAGE_PERF_EN)
//   bubble_cnt        cycles with !dn_valid && dn_ready   (only with PIPE_STAGE_PERF_EN)
//
// Optional build macro: PIPE_STAGE_PERF_EN adds the saturating stall/bubble counters.
// Counters are cleared only by rst_n; flush leaves them alone.

module pipe_stage_latch #(
    parameter int WORD_W = 16,
    parameter int CS_W   = 20,
    parameter int CC_W   = 3,
    parameter int DRID_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [WORD_W-1:0] npc_in,
    input  logic [CS_W-1:0]   cs_in,
    input  logic [WORD_W-1:0] ir_in,
    input  logic [WORD_W-1:0] sr1_in,
    input  logic [WORD_W-1:0] sr2_in,
    input  logic [CC_W-1:0]   cc_in,
    input  logic [DRID_W-1:0] drid_in,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [WORD_W-1:0] npc_out,
    output logic [CS_W-1:0]   cs_out,
    output logic [WORD_W-1:0] ir_out,
    output logic [WORD_W-1:0] sr1_out,
    output logic [WORD_W-1:0] sr2_out,
    output logic [CC_W-1:0]   cc_out,
    output logic [DRID_W-1:0] drid_out
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef struct packed {
        logic [WORD_W-1:0] npc;
        logic [CS_W-1:0]   cs;
        logic [WORD_W-1:0] ir;
        logic [WORD_W-1:0] sr1;
        logic [WORD_W-1:0] sr2;
        logic [CC_W-1:0]   cc;
        logic [DRID_W-1:0] drid;
    } bundle_t;

    // EMPTY: main invalid; ONE: main valid; FULL: main and skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t  r_state;
    state_t  w_state_nxt;
    bundle_t r_main;
    bundle_t r_skid;
    bundle_t w_in;
    logic    w_ld_main;
    logic    w_main_from_skid;
    logic    w_ld_skid;

    assign w_in = '{npc: npc_in, cs: cs_in, ir: ir_in, sr1: sr1_in,
                    sr2: sr2_in, cc: cc_in, drid: drid_in};

    // Both handshake outputs come straight from the state register.
    assign dn_valid = (r_state != EMPTY);
    assign up_ready = (r_state != FULL);

    assign npc_out  = r_main.npc;
    assign cs_out   = r_main.cs;
    assign ir_out   = r_main.ir;
    assign sr1_out  = r_main.sr1;
    assign sr2_out  = r_main.sr2;
    assign cc_out   = r_main.cc;
    assign drid_out = r_main.drid;

    always_comb begin
        w_state_nxt      = r_state;
        w_ld_main        = 1'b0;
        w_main_from_skid = 1'b0;
        w_ld_skid        = 1'b0;
        if (flush) begin
            // Squash everything held; data registers keep stale contents
            // but they are unobservable behind dn_valid=0.
            w_state_nxt = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (up_valid) begin
                        w_ld_main   = 1'b1;
                        w_state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (dn_ready && up_valid) begin
                        w_ld_main = 1'b1;
                    end else if (dn_ready) begin
                        w_state_nxt = EMPTY;
                    end else if (up_valid) begin
                        w_ld_skid   = 1'b1;
                        w_state_nxt = FULL;
                    end
                end
                FULL: begin
                    // Input ignored here: up_ready is low.
                    if (dn_ready) begin
                        w_ld_main        = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ONE;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_main) begin
                r_main <= w_main_from_skid ? r_skid : w_in;
            end
            if (w_ld_skid) begin
                r_skid <= w_in;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

    // Saturating counters: stick at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (dn_valid && !dn_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (!dn_valid && dn_ready && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Purpose : self-checking bench for pipe_stage_latch using a beat scoreboard
// Latency : inputs driven and outputs sampled at the falling edge; DUT transfers at the rising edge
// Backpr. : random and directed valid/ready/flush patterns, bounded drain at the end

module tb_pipe_stage_latch;

    localparam int WORD_W = 16;
    localparam int CS_W   = 20;
    localparam int CC_W   = 3;
    localparam int DRID_W = 3;
    localparam int CNT_W  = 4;
    localparam int BW     = 4 * WORD_W + CS_W + CC_W + DRID_W;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              up_valid;
    logic              up_ready;
    logic [WORD_W-1:0] npc_in, ir_in, sr1_in, sr2_in;
    logic [CS_W-1:0]   cs_in;
    logic [CC_W-1:0]   cc_in;
    logic [DRID_W-1:0] drid_in;
    logic              dn_valid;
    logic              dn_ready;
    logic [WORD_W-1:0] npc_out, ir_out, sr1_out, sr2_out;
    logic [CS_W-1:0]   cs_out;
    logic [CC_W-1:0]   cc_out;
    logic [DRID_W-1:0] drid_out;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
`endif

    int n_err;
    int n_chk;
    logic [BW-1:0] sb_q[$];

    pipe_stage_latch #(
        .WORD_W(WORD_W), .CS_W(CS_W), .CC_W(CC_W), .DRID_W(DRID_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready),
        .npc_in(npc_in), .cs_in(cs_in), .ir_in(ir_in), .sr1_in(sr1_in),
        .sr2_in(sr2_in), .cc_in(cc_in), .drid_in(drid_in),
        .dn_valid(dn_valid), .dn_ready(dn_ready),
        .npc_out(npc_out), .cs_out(cs_out), .ir_out(ir_out), .sr1_out(sr1_out),
        .sr2_out(sr2_out), .cc_out(cc_out), .drid_out(drid_out)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every field is derived from ir so that a beat is identified by its ir value.
    function automatic logic [BW-1:0] mk(input logic [WORD_W-1:0] ir);
        logic [WORD_W-1:0] npc, sr1, sr2;
        logic [CS_W-1:0]   cs;
        npc = ir ^ 16'hA5A5;
        cs  = {4'hC, ir};
        sr1 = ~ir;
        sr2 = ir + 16'd3;
        return {npc, cs, ir, sr1, sr2, ir[2:0], ir[5:3]};
    endfunction

    function automatic logic [BW-1:0] outs();
        return {npc_out, cs_out, ir_out, sr1_out, sr2_out, cc_out, drid_out};
    endfunction

    // Called at a falling edge: checks current outputs against the scoreboard,
    // drives the inputs for the coming rising edge, updates the model with
    // the handshakes that edge will perform, then waits for the next falling edge.
    task automatic cycle(input logic uv, input logic [WORD_W-1:0] ir,
                         input logic dr, input logic fl);
        logic [BW-1:0] b;
        b = mk(ir);
        up_valid = uv;
        dn_ready = dr;
        flush    = fl;
        {npc_in, cs_in, ir_in, sr1_in, sr2_in, cc_in, drid_in} = b;
        check("dn_valid", 128'(dn_valid), 128'(sb_q.size() != 0));
        check("up_ready", 128'(up_ready), 128'(sb_q.size() < 2));
        if (dn_valid && sb_q.size() != 0) begin
            check("bundle", 128'(outs()), 128'(sb_q[0]));
        end
        if (dn_valid && dr && sb_q.size() != 0) begin
            void'(sb_q.pop_front());
        end
        if (fl) begin
            sb_q.delete();
        end else if (uv && up_ready) begin
            sb_q.push_back(b);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_dn_valid", 128'(dn_valid), 128'(0));
        check("rst_up_ready", 128'(up_ready), 128'(1));
        check("rst_ir_out", 128'(ir_out), 128'(0));
`ifdef PIPE_STAGE_PERF_EN
        check("rst_stall_cnt", 128'(stall_cnt), 128'(0));
        check("rst_bubble_cnt", 128'(bubble_cnt), 128'(0));
`endif
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        n_err    = 0;
        n_chk    = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        up_valid = 1'b0;
        dn_ready = 1'b0;
        {npc_in, cs_in, ir_in, sr1_in, sr2_in, cc_in, drid_in} = '0;

        #1;
        check("por_dn_valid", 128'(dn_valid), 128'(0));
        check("por_up_ready", 128'(up_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Stream of five beats at full rate.
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h1000 + 16'(i), 1'b1, 1'b0);
        check("stream_ir_last", 128'(ir_out), 128'(16'h1004));
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);

        // Skid fill with A, B; C must wait until up_ready returns.
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        cycle(1'b1, 16'h5678, 1'b0, 1'b0);
        check("skid_up_ready", 128'(up_ready), 128'(0));
        check("skid_head_A", 128'(ir_out), 128'(16'h1234));
        cycle(1'b1, 16'hC0DE, 1'b1, 1'b0);
        check("skid_head_B", 128'(ir_out), 128'(16'h5678));
        cycle(1'b1, 16'hC0DE, 1'b1, 1'b0);
        check("skid_head_C", 128'(ir_out), 128'(16'hC0DE));
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);

        // Flush while FULL with a beat on offer.
        cycle(1'b1, 16'h1111, 1'b0, 1'b0);
        cycle(1'b1, 16'h2222, 1'b0, 1'b0);
        cycle(1'b1, 16'h9ABC, 1'b0, 1'b1);
        check("flush_dn_valid", 128'(dn_valid), 128'(0));
        check("flush_up_ready", 128'(up_ready), 128'(1));
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-run with beats held.
        cycle(1'b1, 16'h7777, 1'b0, 1'b0);
        cycle(1'b1, 16'h8888, 1'b0, 1'b0);
        do_reset();

`ifdef PIPE_STAGE_PERF_EN
        cycle(1'b1, 16'h4444, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0);
        check("stall_cnt_5", 128'(stall_cnt), 128'(5));
        for (int i = 0; i < 15; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0);
        check("stall_cnt_sat", 128'(stall_cnt), 128'(15));
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
        check("bubble_cnt_3", 128'(bubble_cnt), 128'(3));
        cycle(1'b0, 16'h0, 1'b1, 1'b1);
        check("flush_keeps_stall", 128'(stall_cnt), 128'(15));
`endif

        // Random traffic with occasional flush.
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0,
                  ($urandom % 64) == 0);
        end

        // Bounded drain.
        k = 0;
        while (sb_q.size() != 0 && k < 10) begin
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
            k++;
        end
        check("drain_empty", 128'(sb_q.size()), 128'(0));
        check("drain_dn_valid", 128'(dn_valid), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
